// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single downstream memory/device access path between the core's
// instruction-fetch port and its memU data port. One transaction is in flight
// at a time: the winning request is captured in IDLE and held stable on the
// bus_* outputs for the whole BUSY state. Read data comes back to the granted
// port with a one-cycle ready pulse in RESP. A watchdog aborts a transaction
// that is never acknowledged and returns err = 1 with zero data.
//
// Build option:
//   MEM_ARB_RR_EN  undefined : fixed priority, the data port wins every contention
//   MEM_ARB_RR_EN  defined   : round robin on contention, using a last-grant
//                              register that resets to "fetch"
//
// Parameters:
//   TIMEOUT     maximum BUSY cycles before abort; 0 disables the watchdog
//
// Ports:
//   clk         core clock, rising-edge
//   rst         asynchronous reset, active low
//   if_req      fetch request (always a read)
//   if_addr     fetch address
//   if_ready    one-cycle completion pulse to fetch
//   if_rdata    fetch read data, valid with if_ready, held otherwise
//   if_err      fetch timeout error, valid with if_ready, held otherwise
//   mem_req     data request
//   mem_wen     1 = store, 0 = load
//   mem_addr    data address
//   mem_funct3  RISC-V size/sign code
//   mem_wdata   store data
//   mem_ready   one-cycle completion pulse to memU
//   mem_rdata   load data, valid with mem_ready, held otherwise
//   mem_err     data timeout error, valid with mem_ready, held otherwise
//   bus_valid   downstream request valid (high only in BUSY)
//   bus_wen     downstream write enable
//   bus_addr    downstream address
//   bus_funct3  downstream size code
//   bus_wdata   downstream write data
//   bus_ready   downstream completion; bus_rdata valid this cycle
//   bus_rdata   downstream read data
// -----------------------------------------------------------------------------
// state | meaning
// ------+---------------------------------------------------------------------
// IDLE  | no transaction; arbitrate and capture a request when one is present
// BUSY  | request presented on bus_*; wait for bus_ready or watchdog expiry
// RESP  | one-cycle ready pulse to the granted port; back to IDLE next cycle
// -----------------------------------------------------------------------------

module mem_arbiter #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_ready,
   output logic [63:0] if_rdata,
   output logic        if_err,

   input  logic        mem_req,
   input  logic        mem_wen,
   input  logic [63:0] mem_addr,
   input  logic [2:0]  mem_funct3,
   input  logic [63:0] mem_wdata,
   output logic        mem_ready,
   output logic [63:0] mem_rdata,
   output logic        mem_err,

   output logic        bus_valid,
   output logic        bus_wen,
   output logic [63:0] bus_addr,
   output logic [2:0]  bus_funct3,
   output logic [63:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [63:0] bus_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Fetches are always issued as 32-bit zero-extended loads (LWU).
   localparam logic [2:0] FUNCT3_LWU = 3'b110;

   // The watchdog is a down-counter loaded with TIMEOUT-1 on entry to BUSY;
   // reaching zero without bus_ready means bus_valid has been high for exactly
   // TIMEOUT cycles.
   localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam bit               WDOG_EN  = (TIMEOUT != 0);

   state_t           state;
   state_t           state_nxt;

   logic             any_req;
   logic             pick_mem;
   logic             grant_mem;
   logic             accept;
   logic             finish;

   logic [CNT_W-1:0] wdog_cnt;
   logic             wdog_tc;

   logic             hold_wen;
   logic [63:0]      hold_addr;
   logic [2:0]       hold_funct3;
   logic [63:0]      hold_wdata;

   assign any_req = if_req | mem_req;
   assign accept  = (state == ST_IDLE) && any_req;
   assign wdog_tc = WDOG_EN && (wdog_cnt == '0);
   // bus_ready wins over a simultaneous watchdog expiry.
   assign finish  = (state == ST_BUSY) && (bus_ready || wdog_tc);

   // --------------------------------------------------------------------------
   // Arbitration
   // --------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
   logic last_mem;

   // On contention the port not granted last time wins; a lone requester is
   // granted regardless of history.
   assign pick_mem = mem_req && (!if_req || !last_mem);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_mem <= 1'b0;
      end else if (accept) begin
         last_mem <= pick_mem;
      end
   end
`else
   // Fixed priority: the data port always wins, fetch may be starved.
   assign pick_mem = mem_req;
`endif

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bus_valid = 1'b0;
      if_ready  = 1'b0;
      mem_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            bus_valid = 1'b1;
            if (bus_ready || wdog_tc) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if_ready  = !grant_mem;
            mem_ready = grant_mem;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Request capture and watchdog
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_mem   <= 1'b0;
         hold_wen    <= 1'b0;
         hold_addr   <= '0;
         hold_funct3 <= '0;
         hold_wdata  <= '0;
         wdog_cnt    <= '0;
      end else if (accept) begin
         grant_mem <= pick_mem;
         wdog_cnt  <= CNT_LOAD;
         if (pick_mem) begin
            hold_wen    <= mem_wen;
            hold_addr   <= mem_addr;
            hold_funct3 <= mem_funct3;
            hold_wdata  <= mem_wdata;
         end else begin
            hold_wen    <= 1'b0;
            hold_addr   <= if_addr;
            hold_funct3 <= FUNCT3_LWU;
            hold_wdata  <= '0;
         end
      end else if ((state == ST_BUSY) && !finish && (wdog_cnt != '0)) begin
         wdog_cnt <= wdog_cnt - CNT_W'(1);
      end
   end

   // bus_* fields are driven only while the request is live so that nothing
   // stale is presented downstream between transactions.
   assign bus_wen    = (state == ST_BUSY) ? hold_wen    : 1'b0;
   assign bus_addr   = (state == ST_BUSY) ? hold_addr   : '0;
   assign bus_funct3 = (state == ST_BUSY) ? hold_funct3 : '0;
   assign bus_wdata  = (state == ST_BUSY) ? hold_wdata  : '0;

   // --------------------------------------------------------------------------
   // Response registers
   // Each port keeps its own rdata/err so the values hold between pulses;
   // only the granted port is updated, on the BUSY->RESP edge.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rdata  <= '0;
         if_err    <= 1'b0;
         mem_rdata <= '0;
         mem_err   <= 1'b0;
      end else if (finish) begin
         if (grant_mem) begin
            mem_rdata <= bus_ready ? bus_rdata : '0;
            mem_err   <= !bus_ready;
         end else begin
            if_rdata  <= bus_ready ? bus_rdata : '0;
            if_err    <= !bus_ready;
         end
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single memory/device access path between the instruction-fetch port and the memU data port of the core.
- Sits between the two requesters and the downstream memory access layer (main memory at 0x8000_0000, devices at 0x2000_0000).
- Arbitrates requests, registers the winning request and holds it stable until the downstream acknowledges, then returns read data with a one-cycle ready pulse.
- A watchdog aborts any transaction the downstream never acknowledges.

## Interface

Parameters:
- TIMEOUT, default 1024: max BUSY cycles before abort. 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- if_req  in  1  fetch request (read only)
- if_addr  in  64  fetch address
- if_ready  out  1  one-cycle completion pulse to fetch
- if_rdata  out  64  fetch read data, valid with if_ready
- if_err  out  1  timeout error, valid with if_ready
- mem_req  in  1  data request
- mem_wen  in  1  1 = store, 0 = load
- mem_addr  in  64  data address
- mem_funct3  in  3  RISC-V size/sign code
- mem_wdata  in  64  store data
- mem_ready  out  1  one-cycle completion pulse to memU
- mem_rdata  out  64  load data, valid with mem_ready
- mem_err  out  1  timeout error, valid with mem_ready
- bus_valid  out  1  downstream request valid
- bus_wen  out  1  downstream write enable
- bus_addr  out  64  downstream address
- bus_funct3  out  3  downstream size code
- bus_wdata  out  64  downstream write data
- bus_ready  in  1  downstream completion; bus_rdata valid this cycle
- bus_rdata  in  64  downstream read data

## Operation

The block has three states: IDLE, BUSY and RESP.

IDLE
- If neither request is asserted, the block stays in IDLE.
- Otherwise it picks a winner (see Configuration) and latches the request into holding registers:
  - For a fetch: addr = if_addr, wen = 0, funct3 = 3'b110 (LWU), wdata = 0.
  - For a data access: the mem_* values.
- Next state: BUSY. The watchdog counter is cleared.

BUSY
- bus_valid = 1. All bus_* outputs come from the holding registers and are stable for the whole state.
- On bus_ready = 1: latch bus_rdata into the response register, err = 0, next state RESP.
- Otherwise the counter increments. If TIMEOUT != 0 and counter == TIMEOUT-1 with no bus_ready: response data = 0, err = 1, next state RESP.

RESP
- bus_valid = 0.
- The granted port's ready = 1 for exactly one cycle, with its rdata/err taken from the response register.
- The non-granted port's ready = 0.
- Next state: IDLE.

General rules:
- rdata and err outputs hold their last values when ready = 0.
- A requester must hold req and its request fields until it sees its ready pulse.
- Request fields that change after the IDLE sample are ignored.
- If req is deasserted mid-transaction, the transaction still completes and the ready pulse is still issued.
- Stores return rdata = bus_rdata (don't-care to memU) with ready/err semantics unchanged.
- The loser of arbitration simply waits; its req is re-evaluated in the next IDLE.
- bus_ready seen in IDLE or RESP is ignored.

## Timing

- Reset (rst low, asynchronous) forces:
  - state = IDLE, every output to 0, counter = 0, last-grant = fetch.
  - This takes effect immediately, including mid-transaction: bus_valid drops and no ready pulse is issued for the aborted request.
- Req sampled in IDLE at cycle N:
  - bus_valid rises at N+1.
  - If bus_ready arrives at N+1+k, ready pulses at N+2+k.
  - The next arbitration takes place at N+3+k.
- Minimum turnaround is 3 cycles per transaction (k = 0). Back-to-back transactions are never overlapped.
- Timeout: with no bus_ready, bus_valid stays high for exactly TIMEOUT cycles, then the err pulse arrives on the following cycle.
- bus_ready asserted in the same cycle the counter reaches TIMEOUT-1: the ready wins (err = 0, data latched).

## Configuration

- MEM_ARB_RR_EN undefined: fixed priority. When both requests are asserted in IDLE, mem always wins, so fetch can be starved by continuous data traffic.
- MEM_ARB_RR_EN defined: round robin.
  - A last-grant register (reset = fetch) is updated on every grant.
  - On contention the port not granted last wins, so the first contention after reset goes to mem.
  - A lone requester is always granted regardless of last-grant.

## Test plan

- Fetch only: if_req = 1, if_addr = 0x8000_0000, bus_ready asserted 2 cycles after bus_valid with bus_rdata = 0x0000_0013 -> bus_funct3 = 3'b110, bus_wen = 0; if_ready pulses 1 cycle after bus_ready with if_rdata = 0x13, if_err = 0; mem_ready stays 0.
- Store: mem_req = 1, mem_wen = 1, addr 0x8000_0100, funct3 = 3'b011, wdata 0xDEAD_BEEF_0123_4567, bus_ready immediate -> bus_* match the inputs for the one BUSY cycle; mem_ready pulses at N+2.
- Contention: if_req and mem_req asserted together for 4 transactions with immediate bus_ready:
  - Without MEM_ARB_RR_EN: grants mem, mem, mem, mem.
  - With MEM_ARB_RR_EN: grants mem, if, mem, if.
- Timeout with TIMEOUT = 8 and bus_ready never asserted -> bus_valid high exactly 8 cycles; requester sees ready with err = 1, rdata = 0; block returns to IDLE.
- Request field changes: mem_addr changed and mem_req dropped during BUSY -> bus_addr keeps the originally sampled value and mem_ready still pulses.
- Reset mid-transaction: rst low during BUSY -> bus_valid and all outputs go 0 asynchronously; after release, a new fetch completes normally with the 3-cycle latency.
